// File: rtl/linalg_pkg.sv
// Shared definitions for the linalg stb/ack matrix streaming blocks.
package linalg_pkg;

  localparam int WORD_W = 32;

  // State set shared by the serializer family (mat_serializer, mat_deserializer).
  typedef enum logic {
    GET_MAT  = 1'b0,
    PUT_ELEM = 1'b1
  } ser_state_e;

  // Index width that never collapses to zero bits for a 1-deep dimension.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/mat_serializer.sv
// Accepts a whole M x N matrix in one stb/ack transfer and streams it out one
// 32-bit element per handshake, in row-major or column-major order.
module mat_serializer
  import linalg_pkg::*;
#(
  parameter int M         = 1,
  parameter int N         = 1,
  parameter int COL_MAJOR = 0,
  localparam int RW       = clog2_min1(M),
  localparam int CW       = clog2_min1(N)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [M-1:0][N-1:0][WORD_W-1:0] input_mat,
  input  logic                         input_mat_stb,
  output logic                         input_mat_ack,
  output logic [WORD_W-1:0]            output_elem,
  output logic [RW-1:0]                output_elem_row,
  output logic [CW-1:0]                output_elem_col,
  output logic                         output_elem_last,
  output logic                         output_elem_stb,
  input  logic                         output_elem_ack
);

  localparam logic [RW-1:0] ROW_MAX = RW'(M - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(N - 1);

  ser_state_e                      state_q, state_d;
  logic [M-1:0][N-1:0][WORD_W-1:0] buf_q, buf_d;
  logic [WORD_W-1:0]               elem_q, elem_d;
  logic [RW-1:0]                   row_q, row_d;
  logic [CW-1:0]                   col_q, col_d;
  logic                            stb_q, stb_d;
  logic                            last_q, last_d;
  logic                            ack_q, ack_d;

  logic [RW-1:0]                   nrow;
  logic [CW-1:0]                   ncol;

  // Next (row,col) from the counters; the inner counter wraps at its parameter
  // bound so a 1-deep dimension never increments past its width.
  always_comb begin
    nrow = row_q;
    ncol = col_q;
    if (COL_MAJOR != 0) begin
      if (row_q == ROW_MAX) begin
        nrow = '0;
        ncol = col_q + CW'(1);
      end else begin
        nrow = row_q + RW'(1);
      end
    end else begin
      if (col_q == COL_MAX) begin
        ncol = '0;
        nrow = row_q + RW'(1);
      end else begin
        ncol = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    elem_d  = elem_q;
    row_d   = row_q;
    col_d   = col_q;
    stb_d   = stb_q;
    last_d  = last_q;
    ack_d   = ack_q;
    case (state_q)
      GET_MAT: begin
        ack_d = 1'b1;
        if (input_mat_stb && ack_q) begin
          buf_d   = input_mat;
          ack_d   = 1'b0;
          elem_d  = input_mat[0][0];
          row_d   = '0;
          col_d   = '0;
          stb_d   = 1'b1;
          last_d  = (M * N == 1);
          state_d = PUT_ELEM;
        end
      end
      PUT_ELEM: begin
        if (stb_q && output_elem_ack) begin
          if (last_q) begin
            stb_d   = 1'b0;
            last_d  = 1'b0;
            ack_d   = 1'b1;
            state_d = GET_MAT;
          end else begin
            row_d  = nrow;
            col_d  = ncol;
            elem_d = buf_q[nrow][ncol];
            last_d = (nrow == ROW_MAX) && (ncol == COL_MAX);
          end
        end
      end
      default: state_d = GET_MAT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GET_MAT;
      elem_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      stb_q   <= 1'b0;
      last_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      row_q   <= row_d;
      col_q   <= col_d;
      stb_q   <= stb_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign input_mat_ack    = ack_q;
  assign output_elem      = elem_q;
  assign output_elem_row  = row_q;
  assign output_elem_col  = col_q;
  assign output_elem_last = last_q;
  assign output_elem_stb  = stb_q;

endmodule

// File: tb/tb_mat_serializer.sv
// Directed bench for mat_serializer: row-major, column-major and 1x1 instances.
module tb_mat_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: 2x3 row-major
  logic [1:0][2:0][31:0] a_mat;
  logic        a_mstb, a_mack, a_row, a_last, a_estb, a_eack;
  logic [31:0] a_elem;
  logic [1:0]  a_col;
  // Instance B: 2x3 column-major
  logic [1:0][2:0][31:0] b_mat;
  logic        b_mstb, b_mack, b_row, b_last, b_estb, b_eack;
  logic [31:0] b_elem;
  logic [1:0]  b_col;
  // Instance C: 1x1
  logic [0:0][0:0][31:0] c_mat;
  logic        c_mstb, c_mack, c_row, c_col, c_last, c_estb, c_eack;
  logic [31:0] c_elem;

  mat_serializer #(.M(2), .N(3), .COL_MAJOR(0)) dut_a (
    .clk(clk), .rst(rst), .input_mat(a_mat), .input_mat_stb(a_mstb),
    .input_mat_ack(a_mack), .output_elem(a_elem), .output_elem_row(a_row),
    .output_elem_col(a_col), .output_elem_last(a_last),
    .output_elem_stb(a_estb), .output_elem_ack(a_eack));

  mat_serializer #(.M(2), .N(3), .COL_MAJOR(1)) dut_b (
    .clk(clk), .rst(rst), .input_mat(b_mat), .input_mat_stb(b_mstb),
    .input_mat_ack(b_mack), .output_elem(b_elem), .output_elem_row(b_row),
    .output_elem_col(b_col), .output_elem_last(b_last),
    .output_elem_stb(b_estb), .output_elem_ack(b_eack));

  mat_serializer #(.M(1), .N(1), .COL_MAJOR(0)) dut_c (
    .clk(clk), .rst(rst), .input_mat(c_mat), .input_mat_stb(c_mstb),
    .input_mat_ack(c_mack), .output_elem(c_elem), .output_elem_row(c_row),
    .output_elem_col(c_col), .output_elem_last(c_last),
    .output_elem_stb(c_estb), .output_elem_ack(c_eack));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0][2:0][31:0] mk_mat(input logic [31:0] base);
    logic [1:0][2:0][31:0] m;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        m[r][c] = base + 32'(3 * r + c);
    return m;
  endfunction

  logic [31:0] b_vals [6] = '{32'd1, 32'd4, 32'd2, 32'd5, 32'd3, 32'd6};
  logic        b_rows [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0]  b_cols [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
  logic        bp_ack [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int          bp_idx [9] = '{1, 1, 1, 2, 2, 3, 4, 5, 6};

  initial begin
    rst = 1'b1;
    a_mat = '0; a_mstb = 1'b0; a_eack = 1'b1;
    b_mat = '0; b_mstb = 1'b0; b_eack = 1'b1;
    c_mat = '0; c_mstb = 1'b0; c_eack = 1'b1;
    step();
    step();
    chk("rst_ack", a_mack, 0);
    chk("rst_stb", a_estb, 0);
    chk("rst_last", a_last, 0);
    chk("rst_elem", a_elem, 0);
    chk("rst_rowcol", {a_row, a_col}, 0);
    rst = 1'b0;
    chk("rel_ack_before_edge", a_mack, 0);
    step();
    chk("rel_ack_a", a_mack, 1);
    chk("rel_ack_c", c_mack, 1);

    // Row-major on A and column-major on B, same matrix, ack held high
    a_mat = mk_mat(32'd1); b_mat = mk_mat(32'd1);
    a_mstb = 1'b1; b_mstb = 1'b1;
    step();
    a_mstb = 1'b0; b_mstb = 1'b0;
    chk("acc_ack_low", a_mack, 0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      chk("rm_stb", a_estb, 1);
      chk("rm_elem", a_elem, 32'(k + 1));
      chk("rm_row", a_row, 32'(k / 3));
      chk("rm_col", a_col, 32'(k % 3));
      chk("rm_last", a_last, (k == 5) ? 1 : 0);
      chk("cm_elem", b_elem, b_vals[k]);
      chk("cm_row", b_row, b_rows[k]);
      chk("cm_col", b_col, b_cols[k]);
      chk("cm_last", b_last, (k == 5) ? 1 : 0);
    end
    step();
    chk("rm_done_stb", a_estb, 0);
    chk("rm_done_last", a_last, 0);
    chk("rm_done_ack", a_mack, 1);
    chk("cm_done_stb", b_estb, 0);
    chk("cm_done_ack", b_mack, 1);

    // Next matrix accepted 7 cycles after the first
    a_mat = mk_mat(32'h31); a_mstb = 1'b1;
    step();
    a_mstb = 1'b0;
    chk("rm_next_acc_ack", a_mack, 0);
    chk("rm_next_acc_stb", a_estb, 1);
    chk("bp_e0", a_elem, 32'h31);

    // Backpressure pattern
    for (int i = 0; i < 9; i++) begin
      a_eack = bp_ack[i];
      step();
      if (bp_idx[i] < 6) begin
        chk("bp_stb", a_estb, 1);
        chk("bp_elem", a_elem, 32'h31 + 32'(bp_idx[i]));
        chk("bp_row", a_row, 32'(bp_idx[i] / 3));
        chk("bp_col", a_col, 32'(bp_idx[i] % 3));
        chk("bp_last", a_last, (bp_idx[i] == 5) ? 1 : 0);
      end else begin
        chk("bp_done_stb", a_estb, 0);
        chk("bp_done_ack", a_mack, 1);
      end
    end
    a_eack = 1'b1;

    // Degenerate 1x1
    c_mat[0][0] = 32'hDEADBEEF; c_mstb = 1'b1;
    step();
    c_mstb = 1'b0;
    chk("one_stb", c_estb, 1);
    chk("one_elem", c_elem, 32'hDEADBEEF);
    chk("one_last", c_last, 1);
    chk("one_rowcol", {c_row, c_col}, 0);
    chk("one_ack_low", c_mack, 0);
    step();
    chk("one_done_stb", c_estb, 0);
    chk("one_done_last", c_last, 0);
    chk("one_done_ack", c_mack, 1);

    // Reset mid-stream after 3 of 6 transfers
    a_mat = mk_mat(32'd1); a_mstb = 1'b1;
    step();
    a_mstb = 1'b0;
    step(); step(); step();
    chk("mid_elem_before_rst", a_elem, 4);
    rst = 1'b1;
    #1;
    chk("mid_rst_stb", a_estb, 0);
    chk("mid_rst_ack", a_mack, 0);
    chk("mid_rst_elem", a_elem, 0);
    chk("mid_rst_last", a_last, 0);
    step();
    chk("mid_rst_ack_held", a_mack, 0);
    rst = 1'b0;
    step();
    chk("mid_rel_ack", a_mack, 1);

    // Restart with 0x10.., producer then holds a second matrix 0x20.. busy
    a_mat = mk_mat(32'h10); a_mstb = 1'b1;
    step();
    chk("restart_e0", a_elem, 32'h10);
    chk("restart_rowcol", {a_row, a_col}, 0);
    a_mat = mk_mat(32'h20);
    for (int k = 1; k < 6; k++) begin
      step();
      chk("busy_ack_low", a_mack, 0);
      chk("busy_elem", a_elem, 32'h10 + 32'(k));
    end
    step();
    chk("busy_final_stb", a_estb, 0);
    chk("busy_final_ack", a_mack, 1);
    step();
    a_mstb = 1'b0;
    chk("busy_acc_stb", a_estb, 1);
    chk("busy_acc_elem", a_elem, 32'h20);
    chk("busy_acc_ack", a_mack, 0);
    for (int k = 1; k < 6; k++) begin
      step();
      chk("busy2_elem", a_elem, 32'h20 + 32'(k));
    end
    step();
    chk("busy2_done_stb", a_estb, 0);
    step();
    chk("once_stb", a_estb, 0);
    chk("once_ack", a_mack, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
